// File: rtl/fb_arbiter.sv
// Frame-buffer port arbiter: display pixel fetches take strict priority over
// host writes, which are buffered in a 4-entry FIFO and drained in idle slots.
module fb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pixel_tick,
  input  logic [9:0]  col,
  input  logic [9:0]  row,
  input  logic        wr_req,
  input  logic [18:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  output logic [18:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [15:0] pixel_data,
  output logic        pixel_valid,
  output logic        fetch_overrun
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

  state_t      state;
  logic [18:0] fifo_addr [4];
  logic [15:0] fifo_data [4];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [2:0]  count;
  logic [18:0] fetch_addr;
  logic        fetch_pending;
  logic        rd_cap;

  logic        visible;
  logic [18:0] calc_addr;
  logic        full;
  logic        empty;
  logic        push;
  logic        go_fetch;
  logic        go_write;
  logic        tick_vis;
  logic        tick_blank;

  always_comb begin
    visible    = (col < 10'd640) && (row < 10'd480);
    calc_addr  = {row, 9'b0} + {2'b0, row, 7'b0} + {9'b0, col};
    full       = (count == 3'd4);
    empty      = (count == 3'd0);
    push       = wr_req && !full;
    go_fetch   = fetch_pending && enable;
    go_write   = !go_fetch && !empty && enable;
    tick_vis   = pixel_tick && enable && visible;
    tick_blank = pixel_tick && enable && !visible;
    wr_ready   = !full;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      fetch_addr    <= '0;
      fetch_pending <= 1'b0;
      fetch_overrun <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_re        <= 1'b0;
      mem_we        <= 1'b0;
      rd_cap        <= 1'b0;
      pixel_data    <= '0;
      pixel_valid   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 2'd1;
      if (go_write)
        rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, push} - {2'b0, go_write};

      // A new tick re-arms the pending flag even on the edge that consumes the
      // previous address, so the set has priority over the FETCH clear.
      if (tick_vis) begin
        fetch_addr    <= calc_addr;
        fetch_pending <= 1'b1;
        if (fetch_pending)
          fetch_overrun <= 1'b1;
      end else if (go_fetch) begin
        fetch_pending <= 1'b0;
      end

      if (go_fetch) begin
        state     <= FETCH;
        mem_re    <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= fetch_addr;
        mem_wdata <= '0;
      end else if (go_write) begin
        state     <= WRITE;
        mem_re    <= 1'b0;
        mem_we    <= 1'b1;
        mem_addr  <= fifo_addr[rd_ptr];
        mem_wdata <= fifo_data[rd_ptr];
      end else begin
        state     <= IDLE;
        mem_re    <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
      end

      // Read data arrives the cycle after FETCH; capture it one edge later.
      rd_cap      <= (state == FETCH);
      pixel_valid <= rd_cap;
      if (rd_cap)
        pixel_data <= mem_rdata;
      else if (tick_blank)
        pixel_data <= '0;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Randomized scoreboard bench for fb_arbiter: a queue-based reference model
// predicts memory ops and pixel pulses, a negedge monitor checks them.
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        pixel_tick;
  logic [9:0]  col;
  logic [9:0]  row;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic        fetch_overrun;

  fb_arbiter dut (
    .clk(clk), .rst(rst), .enable(enable), .pixel_tick(pixel_tick),
    .col(col), .row(row), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .fetch_overrun(fetch_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    logic        we;
    logic [18:0] addr;
    logic [15:0] data;
  } op_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } px_t;

  op_t         op_q[$];
  px_t         px_q[$];
  logic [34:0] m_fifo[$];
  logic        m_pending;
  logic [18:0] m_addr;
  logic        m_over;
  logic [15:0] m_pix;
  logic        rdv [2];
  logic [18:0] rda [2];

  function automatic logic [15:0] mem_fn(input logic [18:0] a);
    return a[15:0] ^ {13'h0, a[18:16]} ^ 16'hA5C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Memory: data valid exactly one cycle after mem_re, junk otherwise.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem_fn(mem_addr);
    else        mem_rdata <= 16'($urandom);
  end

  // Reference model, evaluated on each rising edge with the pre-edge inputs.
  always @(posedge clk) begin
    logic        vis;
    logic        rd;
    logic        wr;
    logic        acc;
    logic [34:0] h;
    cyc++;
    if (rst) begin
      m_pending = 1'b0; m_addr = '0; m_over = 1'b0; m_pix = '0;
      rdv[0] = 1'b0; rdv[1] = 1'b0; rda[0] = '0; rda[1] = '0;
      m_fifo.delete(); op_q.delete(); px_q.delete();
    end else begin
      vis = (col < 640) && (row < 480);
      acc = wr_req && (m_fifo.size() < 4);
      rd  = m_pending && enable;
      wr  = !rd && enable && (m_fifo.size() > 0);
      if (rd) begin
        op_q.push_back('{cyc, 1'b0, m_addr, 16'h0});
        px_q.push_back('{cyc + 2, mem_fn(m_addr)});
      end
      if (wr) begin
        h = m_fifo.pop_front();
        op_q.push_back('{cyc, 1'b1, h[34:16], h[15:0]});
      end
      if (rdv[1]) m_pix = mem_fn(rda[1]);
      else if (pixel_tick && enable && !vis) m_pix = '0;
      rdv[1] = rdv[0]; rda[1] = rda[0];
      rdv[0] = rd;     rda[0] = m_addr;
      if (acc) m_fifo.push_back({wr_addr, wr_data});
      if (pixel_tick && enable && vis) begin
        if (m_pending) m_over = 1'b1;
        m_pending = 1'b1;
        m_addr    = 19'(int'(row) * 640 + int'(col));
      end else if (rd) begin
        m_pending = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an op or a pixel.
  always @(negedge clk) begin
    op_t e;
    px_t p;
    if (!rst) begin
      while (op_q.size() > 0 && op_q[0].cyc < cyc) begin
        chk("op_missing_cycle", cyc, op_q[0].cyc);
        void'(op_q.pop_front());
      end
      while (px_q.size() > 0 && px_q[0].cyc < cyc) begin
        chk("pixel_missing_cycle", cyc, px_q[0].cyc);
        void'(px_q.pop_front());
      end
      if (mem_re && mem_we)
        chk("re_we_exclusive", {mem_re, mem_we}, 2'b00);
      if (mem_re || mem_we) begin
        if (op_q.size() == 0 || op_q[0].cyc != cyc) begin
          chk("op_unexpected_cycle", cyc, (op_q.size() > 0) ? op_q[0].cyc : -1);
        end else begin
          e = op_q.pop_front();
          chk("op_kind_we", mem_we, e.we);
          chk("op_addr", mem_addr, e.addr);
          if (e.we) chk("op_wdata", mem_wdata, e.data);
        end
      end else begin
        chk("idle_bus", {mem_addr, mem_wdata}, 35'h0);
      end
      if (pixel_valid) begin
        if (px_q.size() == 0 || px_q[0].cyc != cyc) begin
          chk("pixel_unexpected_cycle", cyc, (px_q.size() > 0) ? px_q[0].cyc : -1);
        end else begin
          p = px_q.pop_front();
          chk("pixel_valid_data", pixel_data, p.data);
        end
      end
      chk("pixel_data", pixel_data, m_pix);
      chk("wr_ready", wr_ready, m_fifo.size() < 4);
      chk("fetch_overrun", fetch_overrun, m_over);
    end
  end

  task automatic drive(input logic en, input logic tk, input int c, input int r,
                       input logic wq, input logic [18:0] wa, input logic [15:0] wd);
    @(negedge clk);
    #1;
    enable = en; pixel_tick = tk; col = 10'(c); row = 10'(r);
    wr_req = wq; wr_addr = wa; wr_data = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 700, 0, 1'b0, '0, '0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; enable = 1'b0; pixel_tick = 1'b0; col = '0; row = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_re", mem_re, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_pixel", {pixel_valid, pixel_data}, 17'h0);
    chk("rst_overrun", fetch_overrun, 1'b0);
    chk("rst_mem_addr", mem_addr, 19'h0);
    rst = 1'b0;

    // Visible fetch at col 5, row 2.
    drive(1'b1, 1'b1, 5, 2, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 5, 2, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    chk("fetch_re_1285", mem_re, 1'b1);
    chk("fetch_addr_1285", mem_addr, 19'd1285);
    idle(4);

    // Corner addresses and a blanking tick.
    drive(1'b1, 1'b1, 639, 479, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 639, 479, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    chk("corner_addr", mem_addr, 19'd307199);
    idle(3);
    drive(1'b1, 1'b1, 640, 0, 1'b0, '0, '0);
    idle(4);

    // Write and fetch armed on the same edge: fetch first, then write.
    drive(1'b1, 1'b1, 100, 200, 1'b1, 19'h12345, 16'hBEEF);
    idle(5);

    // Fill the FIFO while disabled, then drain in blanking.
    for (int i = 0; i < 6; i++)
      drive(1'b0, 1'b0, 10, 10, 1'b1, 19'(20 + i), 16'(16'h1000 + i));
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'(i % 2 == 0), 700, 0, 1'b0, '0, '0);

    // Randomized traffic with the usual every-other-clock tick.
    for (int i = 0; i < 2000; i++) begin
      int c;
      int r;
      c = ($urandom_range(0, 3) == 0) ? $urandom_range(640, 799) : $urandom_range(0, 639);
      r = ($urandom_range(0, 7) == 0) ? $urandom_range(480, 524) : $urandom_range(0, 479);
      drive(($urandom_range(0, 9) != 0), ((i % 2) == 0) && ($urandom_range(0, 5) != 0),
            c, r, ($urandom_range(0, 9) < 3), 19'($urandom), 16'($urandom));
    end
    idle(6);

    // Ticks every clock with enable toggling: overrun must latch and stick.
    for (int i = 0; i < 8; i++)
      drive(1'(i % 3 != 2), 1'b1, 10 + i, 30, 1'b0, '0, '0);
    idle(5);
    chk("overrun_sticky", fetch_overrun, 1'b1);

    // Asynchronous reset while a write is on the bus.
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b0, 700, 0, 1'b1, 19'(300 + i), 16'(16'h2200 + i));
    drive(1'b1, 1'b0, 700, 0, 1'b0, '0, '0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = mem_we;
    end
    chk("write_seen_before_reset", seen, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_we", mem_we, 1'b0);
    chk("async_rst_ready", wr_ready, 1'b1);
    chk("async_rst_overrun", fetch_overrun, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    idle(6);
    chk("post_rst_no_pixel", pixel_valid, 1'b0);

    // Resume on the first tick after reset.
    drive(1'b1, 1'b1, 3, 1, 1'b0, '0, '0);
    idle(6);
    chk("op_q_drained", op_q.size(), 0);
    chk("px_q_drained", px_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all state on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: enable  in  1  global run enable.
REQ-004 SHALL have port: pixel_tick  in  1  one-clk strobe per pixel, once every 2 clk from the divide-by-2 pixel clock.
REQ-005 SHALL have port: col  in  10  current column, 0..799; row  in  10  current row, 0..524.
REQ-006 SHALL have port: wr_req  in  1  host write request; wr_addr  in  19  word address; wr_data  in  16  write data.
REQ-007 SHALL have port: wr_ready  out  1  host write accepted when wr_req && wr_ready.
REQ-008 SHALL have port: mem_addr  out  19; mem_wdata  out  16; mem_re  out  1; mem_we  out  1  shared frame-buffer port.
REQ-009 SHALL have port: mem_rdata  in  16  read data, valid exactly 1 clk after mem_re.
REQ-010 SHALL have port: pixel_data  out  16  display pixel; pixel_valid  out  1  one-clk pulse on each update from memory.
REQ-011 SHALL have port: fetch_overrun  out  1  sticky error flag.

Function
REQ-012 SHALL define visible as col < 640 && row < 480.
REQ-013 SHALL compute fetch address = row*640 + col as 19-bit unsigned (row<<9 + row<<7 + col), max 307199, no truncation.
REQ-014 SHALL latch fetch address and set fetch_pending on pixel_tick && enable && visible.
REQ-015 SHALL, on pixel_tick && enable && !visible, clear pixel_data to 0 next clk with pixel_valid=0 and no memory access.
REQ-016 SHALL buffer host writes in a 4-entry FIFO holding {addr,data}; wr_ready = !full, independent of enable.
REQ-017 SHALL run FSM states IDLE, FETCH, WRITE; exactly one memory op per clk; mem_re and mem_we never both 1.
REQ-018 SHALL, from any state at clk edge, go to FETCH if fetch_pending && enable; else WRITE if FIFO non-empty && enable; else IDLE.
REQ-019 SHALL in FETCH drive mem_re=1, mem_addr=latched fetch address, clear fetch_pending.
REQ-020 SHALL in WRITE drive mem_we=1, mem_addr/mem_wdata=FIFO head, pop FIFO in same clk.
REQ-021 SHALL in IDLE drive mem_re=mem_we=0, mem_addr=0, mem_wdata=0.
REQ-022 SHALL register mem_rdata into pixel_data and pulse pixel_valid the clk after FETCH (pixel latency: tick to pixel_valid = 3 clk).
REQ-023 SHALL give display fetch strict priority over host writes.
REQ-024 SHALL, if pixel_tick qualifies a fetch while fetch_pending still set, overwrite the latched address and set fetch_overrun until reset.
REQ-025 SHALL allow FIFO push and pop in the same clk when not full; count unchanged, order preserved.
REQ-026 SHALL, with enable=0, issue no new memory ops; an op already in FETCH completes its capture; FIFO contents and pending fetch retained.

Reset
REQ-027 SHALL on rst: state=IDLE, FIFO empty, wr_ready=1, fetch_pending=0, mem_re=mem_we=0, mem_addr=0, mem_wdata=0, pixel_data=0, pixel_valid=0, fetch_overrun=0.
REQ-028 SHALL on rst mid-operation abort the in-flight op, discard FIFO contents and suppress pending pixel_valid.
REQ-029 SHALL resume normal operation on the first pixel_tick after rst deasserts.

Verification
REQ-030 Visible fetch: enable=1, col=5,row=2, tick -> mem_re=1 with mem_addr=1285 1 clk later; mem_rdata=0xABCD -> pixel_data=0xABCD, pixel_valid pulse next clk.
REQ-031 Corner address: col=639,row=479 -> mem_addr=307199; col=640,row=0 -> no mem_re, pixel_data=0.
REQ-032 Priority: FIFO holding 1 write, fetch pending in same clk -> FETCH first, WRITE next clk with FIFO head addr/data.
REQ-033 FIFO full: 4 writes during visible line with no free slot -> wr_ready=0; blanking col>=640 -> 4 mem_we pulses in push order, wr_ready=1 after first pop.
REQ-034 Overrun: pixel_tick every clk in visible region with enable toggled low -> fetch_overrun=1, stays 1 until rst.
REQ-035 Async reset: assert rst during WRITE -> mem_we=0 immediately, FIFO empty, no pixel_valid after release.
